// File: rtl/leve1_hazard_ctl_pkg.sv
// Shared types and RV32 decode helpers for the LEVE1 decode-stage issue controller.
package leve1_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SERIAL = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // S/B formats carry immediate bits in the rd field, so they never write a register.
  function automatic logic writes_rd(input logic [6:0] op);
    return !((op == OP_STORE) || (op == OP_BRANCH));
  endfunction

  function automatic logic is_long(input logic [6:0] op, input logic [6:0] f7);
    return (op == OP_LOAD) || ((op == OP_OP) && (f7 == F7_MULDIV));
  endfunction

endpackage

// File: rtl/leve1_hazard_ctl_if.sv
// Fetch/decode, writeback and status signals of the LEVE1 issue controller.
interface leve1_hazard_ctl_if #(
  parameter int NUM_REG = 32,
  parameter int CNT_W   = 32
) ();
  logic               IF_VALID;
  logic [31:0]        IF_INSTR;
  logic               IF_READY;
  logic               IFLASH;
  logic               EX_REDIRECT;
  logic               LWB_VALID;
  logic [4:0]         LWB_RD;
  logic               WB_SYS_DONE;
  logic [NUM_REG-1:0] SB_BUSY;
  logic [3:0]         PEND_CNT;
  logic [CNT_W-1:0]   STALL_CNT;

  modport master (
    output IF_VALID, IF_INSTR, EX_REDIRECT, LWB_VALID, LWB_RD, WB_SYS_DONE,
    input  IF_READY, IFLASH, SB_BUSY, PEND_CNT, STALL_CNT
  );

  modport slave (
    input  IF_VALID, IF_INSTR, EX_REDIRECT, LWB_VALID, LWB_RD, WB_SYS_DONE,
    output IF_READY, IFLASH, SB_BUSY, PEND_CNT, STALL_CNT
  );
endinterface

// File: rtl/leve1_hazard_ctl_scoreboard.sv
// Busy-register vector and in-flight long-op counter with combinational hazard lookup.
module leve1_scoreboard #(
  parameter int NUM_REG  = 32,
  parameter int MAX_PEND = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_set_en,
  input  logic [4:0]         i_set_rd,
  input  logic               i_clr_en,
  input  logic [4:0]         i_clr_rd,
  input  logic [4:0]         i_rs1,
  input  logic               i_rs1_use,
  input  logic [4:0]         i_rs2,
  input  logic               i_rs2_use,
  input  logic [4:0]         i_rd,
  input  logic               i_rd_use,
  input  logic               i_long,
  output logic [NUM_REG-1:0] o_busy,
  output logic [3:0]         o_pend_cnt,
  output logic               o_hazard
);
  logic [NUM_REG-1:0] r_busy;
  logic [NUM_REG-1:0] w_busy_nxt;
  logic [NUM_REG-1:0] w_set_mask;
  logic [NUM_REG-1:0] w_clr_mask;
  logic [3:0]         r_pend;
  logic [3:0]         w_pend_nxt;
  logic               w_dec;

  // x0 is forced clear here, so a long op to x0 only moves the pending count.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_rd] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_rd] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  assign w_dec      = i_clr_en && (r_pend != 4'd0);
  assign w_pend_nxt = r_pend + {3'd0, i_set_en} - {3'd0, w_dec};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      r_pend <= 4'd0;
    end else begin
      r_busy <= w_busy_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  assign o_hazard = (i_rs1_use && r_busy[i_rs1]) ||
                    (i_rs2_use && r_busy[i_rs2]) ||
                    (i_rd_use  && r_busy[i_rd])  ||
                    (i_long    && (r_pend == 4'(MAX_PEND)));

  assign o_busy     = r_busy;
  assign o_pend_cnt = r_pend;

  a_lwb_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_clr_en |-> (r_pend != 4'd0));
endmodule

// File: rtl/leve1_hazard_ctl.sv
// LEVE1 decode issue controller: RAW/WAW/full-queue stall, redirect flush sequencing.
// LEVE1_CSR_SERIAL_EN: hold SYSTEM ops until drained, then wait in SERIAL for WB_SYS_DONE.
module leve1_hazard_ctl
  import leve1_pkg::*;
#(
  parameter int NUM_REG      = 32,
  parameter int MAX_PEND     = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic              CLK,
  input logic              RSTn,
  leve1_hazard_ctl_if.slave bus
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t             r_state, w_state_nxt;
  logic [FC_W-1:0]    r_flush_cnt, w_flush_cnt_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [6:0]         w_op, w_f7;
  logic [4:0]         w_rd, w_rs1, w_rs2;
  logic               w_long, w_sb_haz, w_sys_hold, w_hazard;
  logic               w_if_ready, w_iflash, w_issue;
  logic [NUM_REG-1:0] w_busy;
  logic [3:0]         w_pend;

  assign w_op   = bus.IF_INSTR[6:0];
  assign w_rd   = bus.IF_INSTR[11:7];
  assign w_rs1  = bus.IF_INSTR[19:15];
  assign w_rs2  = bus.IF_INSTR[24:20];
  assign w_f7   = bus.IF_INSTR[31:25];
  assign w_long = is_long(w_op, w_f7);

  leve1_scoreboard #(.NUM_REG(NUM_REG), .MAX_PEND(MAX_PEND)) u_sb (
    .i_clk      (CLK),
    .i_rst_n    (RSTn),
    .i_set_en   (w_issue && w_long),
    .i_set_rd   (w_rd),
    .i_clr_en   (bus.LWB_VALID),
    .i_clr_rd   (bus.LWB_RD),
    .i_rs1      (w_rs1),
    .i_rs1_use  (uses_rs1(w_op)),
    .i_rs2      (w_rs2),
    .i_rs2_use  (uses_rs2(w_op)),
    .i_rd       (w_rd),
    .i_rd_use   (writes_rd(w_op)),
    .i_long     (w_long),
    .o_busy     (w_busy),
    .o_pend_cnt (w_pend),
    .o_hazard   (w_sb_haz)
  );

`ifdef LEVE1_CSR_SERIAL_EN
  assign w_sys_hold = (w_op == OP_SYSTEM) && ((w_pend != 4'd0) || (w_busy != '0));
`else
  assign w_sys_hold = 1'b0;
`endif

  assign w_hazard = w_sb_haz || w_sys_hold;
  assign w_iflash = (r_state == FLUSH);

  // Flush counter loads FLUSH_CYCLES-1 so IFLASH is high for exactly FLUSH_CYCLES cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_if_ready      = 1'b0;
    case (r_state)
      RUN: begin
        w_if_ready = !w_hazard;
        if (bus.EX_REDIRECT) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
        end
`ifdef LEVE1_CSR_SERIAL_EN
        else if (bus.IF_VALID && !w_hazard && (w_op == OP_SYSTEM)) begin
          w_state_nxt = SERIAL;
        end
`endif
      end
      FLUSH: begin
        w_if_ready = 1'b1;
        if (bus.EX_REDIRECT) begin
          w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
        end else if (r_flush_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        end
      end
      SERIAL: begin
        if (bus.EX_REDIRECT) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
        end else if (bus.WB_SYS_DONE) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_issue = bus.IF_VALID && w_if_ready && !w_iflash;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (bus.IF_VALID && !w_if_ready && !w_iflash) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.IF_READY  = w_if_ready;
  assign bus.IFLASH    = w_iflash;
  assign bus.SB_BUSY   = w_busy;
  assign bus.PEND_CNT  = w_pend;
  assign bus.STALL_CNT = r_stall_cnt;
endmodule

// File: tb/tb_leve1_hazard_ctl.sv
// Scoreboard bench for leve1_hazard_ctl; the SYSTEM test follows LEVE1_CSR_SERIAL_EN.
module tb_leve1_hazard_ctl;
  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  leve1_hazard_ctl_if #(.NUM_REG(32), .CNT_W(32)) bus ();

  leve1_hazard_ctl #(.NUM_REG(32), .MAX_PEND(4), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_issued = 0;
  int exp_stall = 0;

  typedef struct {
    string       tag;
    logic [31:0] ins;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd);
    return itype(12'd0, 5'd1, 3'b010, rd, 7'b0000011);
  endfunction

  function automatic logic [31:0] div(input logic [4:0] rd);
    return rtype(7'b0000001, 5'd9, 5'd8, 3'b100, rd, 7'b0110011);
  endfunction

  // Any issue seen by the DUT pops the oldest expectation and checks opcode and cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (RSTn && bus.IF_VALID && bus.IF_READY && !bus.IFLASH) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_issue", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk({e.tag, "_instr"}, bus.IF_INSTR, e.ins);
        chk({e.tag, "_cycle"}, cyc, e.cyc);
      end
      n_issued++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input string tag, input int lat);
    exp_t e;
    e.tag = tag;
    e.ins = ins;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    bus.IF_VALID = 1'b1;
    bus.IF_INSTR = ins;
  endtask

  task automatic wait_issue(input string tag, input int budget);
    int n0;
    int k;
    n0 = n_issued;
    k  = 0;
    do begin
      step();
      k++;
    end while (n_issued == n0 && k < budget);
    if (n_issued == n0) chk({tag, "_timeout"}, 64'd0, 64'd1);
    bus.IF_VALID = 1'b0;
  endtask

  task automatic lwb(input logic [4:0] rd);
    bus.LWB_VALID = 1'b1;
    bus.LWB_RD    = rd;
    step();
    bus.LWB_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    bus.IF_VALID    = 1'b0;
    bus.IF_INSTR    = 32'd0;
    bus.EX_REDIRECT = 1'b0;
    bus.LWB_VALID   = 1'b0;
    bus.LWB_RD      = 5'd0;
    bus.WB_SYS_DONE = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;

    @(negedge CLK);
    chk("rst_pend",   bus.PEND_CNT, 0);
    chk("rst_sb",     bus.SB_BUSY, 0);
    chk("rst_stall",  bus.STALL_CNT, 0);
    chk("rst_iflash", bus.IFLASH, 0);
    chk("rst_ready",  bus.IF_READY, 1);
    step();

    // lw x5 then dependent add: stalled until the cycle after the release
    offer(lw(5'd5), "t1_lw", 0);
    wait_issue("t1_lw", 3);
    chk("t1_pend", bus.PEND_CNT, 1);
    chk("t1_sb",   bus.SB_BUSY, 32'h20);
    offer(rtype(7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011), "t1_add", 3);
    @(negedge CLK); chk("t1_stall_a", bus.IF_READY, 0); step();
    @(negedge CLK); chk("t1_stall_b", bus.IF_READY, 0); step();
    bus.LWB_VALID = 1'b1; bus.LWB_RD = 5'd5;
    @(negedge CLK); chk("t1_stall_c", bus.IF_READY, 0); step();
    bus.LWB_VALID = 1'b0;
    wait_issue("t1_add", 3);
    exp_stall += 3;
    chk("t1_stallcnt", bus.STALL_CNT, exp_stall);
    chk("t1_pend_end", bus.PEND_CNT, 0);
    chk("t1_sb_end",   bus.SB_BUSY, 0);

    // four divs fill the queue; the fifth waits for one release
    for (int k = 1; k <= 4; k++) begin
      offer(div(5'(k)), "t2_div", 0);
      wait_issue("t2_div", 3);
    end
    chk("t2_pend_full", bus.PEND_CNT, 4);
    chk("t2_sb_full",   bus.SB_BUSY, 32'h1E);
    offer(div(5'd7), "t2_div7", 2);
    @(negedge CLK); chk("t2_stall_a", bus.IF_READY, 0); step();
    bus.LWB_VALID = 1'b1; bus.LWB_RD = 5'd1;
    @(negedge CLK); chk("t2_stall_b", bus.IF_READY, 0); step();
    bus.LWB_VALID = 1'b0;
    wait_issue("t2_div7", 3);
    exp_stall += 2;
    chk("t2_stallcnt", bus.STALL_CNT, exp_stall);
    chk("t2_pend",     bus.PEND_CNT, 4);
    chk("t2_sb",       bus.SB_BUSY, 32'h9C);
    lwb(5'd2); lwb(5'd3); lwb(5'd4); lwb(5'd7);
    chk("t2_pend_drain", bus.PEND_CNT, 0);
    chk("t2_sb_drain",   bus.SB_BUSY, 0);

    // long op to x0 counts but never marks x0 busy
    offer(lw(5'd0), "t3_lw0", 0);
    wait_issue("t3_lw0", 3);
    chk("t3_pend", bus.PEND_CNT, 1);
    chk("t3_sb",   bus.SB_BUSY, 0);
    offer(32'h0000_0033, "t3_add0", 0);
    wait_issue("t3_add0", 3);
    chk("t3_stallcnt", bus.STALL_CNT, exp_stall);
    lwb(5'd0);
    chk("t3_pend_end", bus.PEND_CNT, 0);

    // issue of lw x6 in the same cycle as the release of x5
    offer(lw(5'd5), "t5_lw5", 0);
    wait_issue("t5_lw5", 3);
    offer(lw(5'd6), "t5_lw6", 0);
    bus.LWB_VALID = 1'b1; bus.LWB_RD = 5'd5;
    wait_issue("t5_lw6", 3);
    bus.LWB_VALID = 1'b0;
    chk("t5_pend", bus.PEND_CNT, 1);
    chk("t5_sb",   bus.SB_BUSY, 32'h40);
    lwb(5'd6);
    chk("t5_pend_end", bus.PEND_CNT, 0);

    // redirect at t, second redirect at t+2: IFLASH t+1..t+4, fetch drains
    bus.EX_REDIRECT = 1'b1;
    @(negedge CLK); chk("t4_iflash_t0", bus.IFLASH, 0); step();
    bus.EX_REDIRECT = 1'b0;
    bus.IF_VALID = 1'b1; bus.IF_INSTR = lw(5'd9);
    @(negedge CLK); chk("t4_iflash_t1", bus.IFLASH, 1); chk("t4_ready_t1", bus.IF_READY, 1); step();
    bus.EX_REDIRECT = 1'b1;
    @(negedge CLK); chk("t4_iflash_t2", bus.IFLASH, 1); step();
    bus.EX_REDIRECT = 1'b0;
    @(negedge CLK); chk("t4_iflash_t3", bus.IFLASH, 1); step();
    @(negedge CLK); chk("t4_iflash_t4", bus.IFLASH, 1); step();
    bus.IF_VALID = 1'b0;
    @(negedge CLK); chk("t4_iflash_t5", bus.IFLASH, 0);
    chk("t4_pend", bus.PEND_CNT, 0);
    chk("t4_sb",   bus.SB_BUSY, 0);
    chk("t4_stallcnt", bus.STALL_CNT, exp_stall);
    step();

    // SYSTEM op with a load outstanding
    offer(lw(5'd5), "t6_lw", 0);
    wait_issue("t6_lw", 3);
`ifdef LEVE1_CSR_SERIAL_EN
    offer(itype(12'h300, 5'd11, 3'b001, 5'd10, 7'b1110011), "t6_csr", 2);
    @(negedge CLK); chk("t6_hold_a", bus.IF_READY, 0); step();
    bus.LWB_VALID = 1'b1; bus.LWB_RD = 5'd5;
    @(negedge CLK); chk("t6_hold_b", bus.IF_READY, 0); step();
    bus.LWB_VALID = 1'b0;
    wait_issue("t6_csr", 3);
    exp_stall += 2;
    @(negedge CLK); chk("t6_serial_a", bus.IF_READY, 0); step();
    bus.WB_SYS_DONE = 1'b1;
    @(negedge CLK); chk("t6_serial_b", bus.IF_READY, 0); step();
    bus.WB_SYS_DONE = 1'b0;
    @(negedge CLK); chk("t6_run", bus.IF_READY, 1); step();
`else
    offer(itype(12'h300, 5'd11, 3'b001, 5'd10, 7'b1110011), "t6_csr", 0);
    wait_issue("t6_csr", 3);
    @(negedge CLK); chk("t6_run", bus.IF_READY, 1); step();
    lwb(5'd5);
`endif
    chk("t6_pend", bus.PEND_CNT, 0);
    chk("t6_stallcnt", bus.STALL_CNT, exp_stall);

    // asynchronous reset in the middle of a flush with a load in flight
    offer(lw(5'd5), "t7_lw", 0);
    wait_issue("t7_lw", 3);
    bus.EX_REDIRECT = 1'b1;
    step();
    bus.EX_REDIRECT = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    chk("t7_iflash", bus.IFLASH, 0);
    chk("t7_pend",   bus.PEND_CNT, 0);
    chk("t7_sb",     bus.SB_BUSY, 0);
    chk("t7_stall",  bus.STALL_CNT, 0);
    step();
    step();
    RSTn = 1'b1;
    @(negedge CLK); chk("t7_ready", bus.IF_READY, 1);

    chk("sb_queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
